// File: rtl/izhikevich_spike_encoder_if.sv
// Spike event stream between the encoder FIFO head and the router/readout.
// master drives the event, slave returns ready.
interface izhikevich_spike_encoder_if #(
    parameter int TS_W = 16,
    parameter int ID_W = 8
);
    logic            valid;
    logic            ready;
    logic [TS_W-1:0] timestamp;
    logic [ID_W-1:0] id;

    modport master (
        output valid, timestamp, id,
        input  ready
    );

    modport slave (
        input  valid, timestamp, id,
        output ready
    );
endinterface

// File: rtl/izhikevich_spike_encoder.sv
// Izhikevich spike encoder: threshold detect, timestamp, FWFT event FIFO.
// Optional spike-rate window counter built when SPIKE_RATE_COUNT_EN is defined.
module izhikevich_spike_encoder #(
    parameter int N      = 32,
    parameter int Q      = 16,
    parameter int TS_W   = 16,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 8,
    parameter int WINDOW = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     apply,
    input  logic [N-1:0]             voltage,
    input  logic [N-1:0]             v_th,
    input  logic [ID_W-1:0]          neuron_id,
    izhikevich_spike_encoder_if.master out,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic [TS_W-1:0]          timestep,
    output logic                     overflow,
    output logic [15:0]              rate_count,
    output logic                     rate_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + ID_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;
    logic   run;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        run        = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                run = 1'b1;
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Same raw signed compare the core uses for its reset.
    logic spike;
    logic step;
    assign spike = $signed(voltage) > $signed(v_th);
    assign step  = run && apply;

    always_ff @(posedge clk) begin
        if (rst)       timestep <= '0;
        else if (step) timestep <= timestep + 1'b1;
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_req;
    logic          pop;
    logic          push;
    logic [EW-1:0] head;

    assign full     = (out_count == FULL);
    assign push_req = step && spike;
    assign pop      = out.valid && out.ready;
    // When full, a simultaneous pop frees the slot being written.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= {timestep, neuron_id};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr];
    assign out.valid     = (out_count != '0);
    assign out.timestamp = out.valid ? head[EW-1:ID_W] : '0;
    assign out.id        = out.valid ? head[ID_W-1:0]  : '0;

`ifdef SPIKE_RATE_COUNT_EN
    localparam int WW = $clog2(WINDOW) + 1;
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

    logic [WW-1:0] win_cnt;
    logic [15:0]   acc;
    logic [15:0]   acc_inc;

    assign acc_inc = (spike && acc != 16'hFFFF) ? acc + 16'd1 : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            acc        <= '0;
            rate_count <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (step) begin
                if (win_cnt == WLAST) begin
                    rate_count <= acc_inc;
                    rate_valid <= 1'b1;
                    acc        <= '0;
                    win_cnt    <= '0;
                end else begin
                    acc     <= acc_inc;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign rate_count = '0;
    assign rate_valid = 1'b0;
`endif

endmodule
